// File: rtl/instr_fetch.sv
// instr_fetch: MIPS instruction fetch stage.
// Owns the program counter and issues sequential word fetches to an
// instruction memory with a fixed one-cycle read latency. Returned words are
// buffered in a DEPTH-entry prefetch queue and presented to the decoder as
// {instr, pc} over a valid/ready handshake. A redirect flushes the queue and
// restarts fetch at the new target.
// Optional feature macro: INSTR_FETCH_CNT_EN adds fetch_cnt_o, a count of
// delivered instructions.
`timescale 1ns/1ps

module instr_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
`ifdef INSTR_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Fetch control state.
    logic              run;
    logic [31:0]       fetch_pc;
    logic              inflight;
    logic [31:0]       inflight_pc;

    // Prefetch queue: circular buffer, DEPTH is a power of two so the
    // pointers wrap naturally.
    logic [31:0]       q_instr [DEPTH];
    logic [31:0]       q_pc    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              pop;
    logic              push;
    logic              req;
    logic [CNT_W:0]    level;

    // The low two bits of the redirect target are forced to zero.
    logic              unused_rpc_bits;
    assign unused_rpc_bits = ^redirect_pc_i[1:0];

    // Handshake, request and push qualification.
    // An in-flight word can only be discarded in its own response cycle,
    // because no request issues during a redirect; redirect_i itself
    // therefore acts as the kill qualifier for the returning word.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        valid_o = 1'b0;
        pop     = 1'b0;
        push    = 1'b0;
        req     = 1'b0;
        level   = '0;

        valid_o = (count != '0);
        pop     = valid_o & ready_i;
        level   = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        req     = run & ~redirect_i & ((level < (CNT_W+1)'(DEPTH)) | pop);
        push    = inflight & ~redirect_i;
    end

    assign imem_req_o  = req;
    assign imem_addr_o = fetch_pc;
    assign instr_o     = q_instr[rd_ptr];
    assign pc_o        = q_pc[rd_ptr];
    assign pc_plus4_o  = pc_o + 32'd4;

    // Program counter, run flag and in-flight request tracking.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_i) begin
            run         <= 1'b0;
            fetch_pc    <= PC_RESET;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            run <= 1'b1;
            if (redirect_i) begin
                fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            end else if (req) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            inflight <= req;
            if (req) begin
                inflight_pc <= fetch_pc;
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: capture the returning word with the pc it was fetched from.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: the storage is reset because instr_o/pc_o must read zero out of reset; it is only DEPTH entries.
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (push) begin
            q_instr[wr_ptr] <= imem_data_i;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end

`ifdef INSTR_FETCH_CNT_EN
    // Delivered-instruction counter; survives redirects, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_o <= '0;
        end else if (pop) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch.
// Directed table for start-up, stall, redirect and wrap-around, hand-written
// mid-stream reset sequence, and randomized traffic checked against a
// queue-based reference model. Honours INSTR_FETCH_CNT_EN when defined.
`timescale 1ns/1ps

module tb_instr_fetch;

    localparam int          DEPTH      = 2;
    localparam logic [31:0] MAIN_RESET = 32'h0000_0000;
    localparam logic [31:0] WRAP_RESET = 32'hFFFF_FFF8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        ready_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i = '0;
    logic        valid_o;
    logic [31:0] instr_o, pc_o, pc_plus4_o;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_data = '0;
    logic        w_valid;
    logic [31:0] w_instr, w_pc, w_pc_plus4;

`ifdef INSTR_FETCH_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] w_fetch_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    instr_fetch #(.PC_RESET(MAIN_RESET), .DEPTH(DEPTH)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
`ifdef INSTR_FETCH_CNT_EN
        , .fetch_cnt_o(fetch_cnt_o)
`endif
    );

    instr_fetch #(.PC_RESET(WRAP_RESET), .DEPTH(DEPTH)) u_wrap (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(w_imem_req), .imem_addr_o(w_imem_addr), .imem_data_i(w_imem_data),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .valid_o(w_valid), .ready_i(ready_i),
        .instr_o(w_instr), .pc_o(w_pc), .pc_plus4_o(w_pc_plus4)
`ifdef INSTR_FETCH_CNT_EN
        , .fetch_cnt_o(w_fetch_cnt)
`endif
    );

    // Memory content: distinct from the address so instr/pc swaps show up.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C00_00A5;
    endfunction

    // One-cycle-latency memories: sample the request mid-cycle, answer after
    // the next edge; unrequested cycles carry random junk.
    initial begin : mem_main
        logic        r;
        logic [31:0] a;
        forever begin
            @(negedge clk_i);
            r = imem_req_o;
            a = imem_addr_o;
            @(posedge clk_i);
            #1;
            imem_data_i = r ? mem_word(a) : $urandom;
        end
    end

    initial begin : mem_wrap
        logic        r;
        logic [31:0] a;
        forever begin
            @(negedge clk_i);
            r = w_imem_req;
            a = w_imem_addr;
            @(posedge clk_i);
            #1;
            w_imem_data = r ? mem_word(a) : $urandom;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model of the main instance: queue of delivered-in-order pcs.
    bit          m_run;
    logic [31:0] m_fetch;
    logic [31:0] m_q[$];
    bit          m_inf;
    logic [31:0] m_inf_pc;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_run   = 1'b0;
        m_fetch = MAIN_RESET;
        m_q.delete();
        m_inf   = 1'b0;
        m_inf_pc = '0;
        m_cnt   = '0;
    endtask

    // Compare this cycle's outputs with the model, then advance the model
    // across the coming clock edge using the inputs currently applied.
    task automatic model_step();
        bit          exp_valid;
        bit          pop;
        bit          exp_req;
        int          level;
        logic [31:0] head;
        exp_valid = (m_q.size() != 0);
        pop       = exp_valid && ready_i;
        level     = m_q.size() + (m_inf ? 1 : 0);
        exp_req   = m_run && !redirect_i && ((level < DEPTH) || pop);
        check("m_valid", 32'(valid_o), 32'(exp_valid));
        if (exp_valid) begin
            head = m_q[0];
            check("m_pc", pc_o, head);
            check("m_instr", instr_o, mem_word(head));
            check("m_pc_plus4", pc_plus4_o, head + 32'd4);
        end
        check("m_req", 32'(imem_req_o), 32'(exp_req));
        if (exp_req) check("m_addr", imem_addr_o, m_fetch);
`ifdef INSTR_FETCH_CNT_EN
        check("m_cnt", fetch_cnt_o, m_cnt);
`endif
        if (pop) begin
            void'(m_q.pop_front());
            m_cnt = m_cnt + 32'd1;
        end
        if (redirect_i) begin
            m_q.delete();
            m_fetch = {redirect_pc_i[31:2], 2'b00};
            m_inf   = 1'b0;
        end else begin
            if (m_inf) m_q.push_back(m_inf_pc);
            m_inf = exp_req;
            if (exp_req) begin
                m_inf_pc = m_fetch;
                m_fetch  = m_fetch + 32'd4;
            end
        end
        m_run = 1'b1;
    endtask

    // One clock cycle: inputs change just after the edge, outputs are
    // examined at the falling edge.
    task automatic cycle(input logic r, input logic rd, input logic [31:0] rpc);
        @(posedge clk_i);
        #1;
        ready_i       = r;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        @(negedge clk_i);
        model_step();
    endtask

    // Release reset mid-cycle; the following edge is edge 1, which only sets run.
    task automatic release_reset();
        @(negedge clk_i);
        #1;
        ready_i    = 1'b1;
        redirect_i = 1'b0;
        rst_i      = 1'b1;
        model_reset();
        m_run = 1'b1;
        #1;
        check("rel_req", 32'(imem_req_o), 32'd0);
        check("rel_valid", 32'(valid_o), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(valid_o), 32'd0);
        check({tag, "_req"}, 32'(imem_req_o), 32'd0);
        check({tag, "_addr"}, imem_addr_o, MAIN_RESET);
        check({tag, "_instr"}, instr_o, 32'd0);
        check({tag, "_pc"}, pc_o, 32'd0);
        check({tag, "_pc_plus4"}, pc_plus4_o, 32'd4);
        check({tag, "_w_addr"}, w_imem_addr, WRAP_RESET);
        check({tag, "_w_req"}, 32'(w_imem_req), 32'd0);
`ifdef INSTR_FETCH_CNT_EN
        check({tag, "_cnt"}, fetch_cnt_o, 32'd0);
        check({tag, "_w_cnt"}, w_fetch_cnt, 32'd0);
`endif
    endtask

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        wchk;
        logic [31:0] wpc;
    } vec_t;

    vec_t tbl[20];

    task automatic random_traffic(input int n);
        logic        r;
        logic        rd;
        logic [31:0] rpc;
        for (int i = 0; i < n; i++) begin
            r   = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            cycle(r, rd, rpc);
        end
    endtask

    initial begin
        // Rows are cycles 1..20 after reset release.
        //            ready redir rpc            req  addr           valid pc             cnt  wchk wpc
        tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'd0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h0,         32'd0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'd0, 1'b1, 32'hFFFF_FFF8};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'd0, 1'b1, 32'hFFFF_FFF8};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'd0, 1'b1, 32'hFFFF_FFF8};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'd0, 1'b1, 32'hFFFF_FFF8};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'd0, 1'b1, 32'hFFFF_FFF8};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'd0, 1'b1, 32'hFFFF_FFF8};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004, 32'd1, 1'b1, 32'hFFFF_FFFC};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'd2, 1'b1, 32'h0000_0000};
        tbl[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0014, 1'b1, 32'h0000_000C, 32'd3, 1'b1, 32'h0000_0004};
        tbl[11] = '{1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010, 32'd4, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'd5, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b0, 32'h0,         32'd5, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100, 32'd5, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_010C, 1'b1, 32'h0000_0104, 32'd6, 1'b0, 32'h0};
        tbl[16] = '{1'b1, 1'b1, 32'h0000_0301, 1'b0, 32'h0000_0200, 1'b0, 32'h0,         32'd6, 1'b0, 32'h0};
        tbl[17] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0300, 1'b0, 32'h0,         32'd6, 1'b0, 32'h0};
        tbl[18] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0304, 1'b0, 32'h0,         32'd6, 1'b0, 32'h0};
        tbl[19] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0308, 1'b1, 32'h0000_0300, 32'd6, 1'b0, 32'h0};

        // Reset values while reset is held.
        repeat (2) @(negedge clk_i);
        check_reset_values("rst");
        release_reset();

        // Directed table: start-up, stall, redirect, back-to-back redirects, wrap.
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].ready, tbl[i].redir, tbl[i].rpc);
            check($sformatf("t%0d_req", i + 1), 32'(imem_req_o), 32'(tbl[i].req));
            check($sformatf("t%0d_addr", i + 1), imem_addr_o, tbl[i].addr);
            check($sformatf("t%0d_valid", i + 1), 32'(valid_o), 32'(tbl[i].valid));
            if (tbl[i].valid) begin
                check($sformatf("t%0d_pc", i + 1), pc_o, tbl[i].pc);
                check($sformatf("t%0d_instr", i + 1), instr_o, mem_word(tbl[i].pc));
                check($sformatf("t%0d_pc_plus4", i + 1), pc_plus4_o, tbl[i].pc + 32'd4);
            end
`ifdef INSTR_FETCH_CNT_EN
            check($sformatf("t%0d_cnt", i + 1), fetch_cnt_o, tbl[i].cnt);
`endif
            if (tbl[i].wchk) begin
                check($sformatf("t%0d_w_valid", i + 1), 32'(w_valid), 32'd1);
                check($sformatf("t%0d_w_pc", i + 1), w_pc, tbl[i].wpc);
                check($sformatf("t%0d_w_instr", i + 1), w_instr, mem_word(tbl[i].wpc));
                check($sformatf("t%0d_w_pc_plus4", i + 1), w_pc_plus4, tbl[i].wpc + 32'd4);
            end
        end

        // Randomized traffic against the reference model.
        random_traffic(1500);

        // Fill the queue, then pull reset mid-cycle.
        repeat (6) cycle(1'b0, 1'b0, 32'h0);
        check("full_valid", 32'(valid_o), 32'd1);
        check("full_req", 32'(imem_req_o), 32'd0);
        #2;
        rst_i = 1'b0;
        #1;
        check_reset_values("mid_rst");
        repeat (2) @(posedge clk_i);
        release_reset();

        // Restart timing after the mid-stream reset.
        cycle(1'b1, 1'b0, 32'h0);
        check("rs1_req", 32'(imem_req_o), 32'd1);
        check("rs1_addr", imem_addr_o, MAIN_RESET);
        cycle(1'b1, 1'b0, 32'h0);
        check("rs2_valid", 32'(valid_o), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        check("rs3_valid", 32'(valid_o), 32'd1);
        check("rs3_pc", pc_o, MAIN_RESET);
        check("rs3_instr", instr_o, mem_word(MAIN_RESET));

        random_traffic(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
